// File: rtl/bht_ctrl.sv
// Branch history table controller. This block owns the single BHT port.
// It sweeps the table to "weakly not taken" after reset. It serves fetch
// prediction reads. It queues committed branch outcomes and applies them
// one at a time as read-modify-write updates of the 2-bit counters.
module bht_ctrl #(
  parameter int INDEX_LEN  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd_ena,
  input  logic                 upd_hit,
  input  logic [31:0]          upd_pc,
  output logic                 upd_full,
  input  logic                 query_valid,
  input  logic [31:0]          query_pc,
  output logic                 query_grant,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic                 init_busy,
  output logic [INDEX_LEN-1:0] bht_addr,
  output logic                 bht_we,
  output logic [1:0]           bht_wdata,
  input  logic [1:0]           bht_rdata
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = INDEX_LEN + 1;
  localparam logic [INDEX_LEN-1:0] SWEEP_LAST = '1;
  localparam logic [PTR_W:0]       COUNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {INIT, IDLE, WB} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [INDEX_LEN-1:0] r_sweepCnt;
  logic [INDEX_LEN-1:0] r_lastAddr;
  logic                 r_predValid;

  logic [ENTRY_W-1:0]   r_fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [PTR_W:0]       r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [ENTRY_W-1:0]   w_head;
  logic                 w_headHit;
  logic [INDEX_LEN-1:0] w_headIdx;
  logic [INDEX_LEN-1:0] w_updIdx;
  logic [INDEX_LEN-1:0] w_queryIdx;
  logic [1:0]           w_satCnt;
  logic                 w_unusedPcBits;

  assign w_updIdx   = upd_pc[INDEX_LEN+1:2];
  assign w_queryIdx = query_pc[INDEX_LEN+1:2];
  assign w_unusedPcBits = ^{upd_pc[31:INDEX_LEN+2], upd_pc[1:0],
                            query_pc[31:INDEX_LEN+2], query_pc[1:0]};

  assign w_full    = (r_count == COUNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_head    = r_fifoMem[r_rdPtr];
  assign w_headHit = w_head[INDEX_LEN];
  assign w_headIdx = w_head[INDEX_LEN-1:0];
  assign w_push    = upd_ena & ~w_full;
  assign w_pop     = (r_state == WB);

  assign upd_full   = w_full;
  assign init_busy  = (r_state == INIT);
  assign pred_valid = r_predValid;
  assign pred_taken = r_predValid & bht_rdata[1];

  // Saturating counter step for the head entry, using the value read last cycle
  always_comb begin
    w_satCnt = bht_rdata;
    if (w_headHit) begin
      if (bht_rdata != 2'b11) w_satCnt = bht_rdata + 2'd1;
    end else begin
      if (bht_rdata != 2'b00) w_satCnt = bht_rdata - 2'd1;
    end
  end

  // Port arbitration and next state; a full queue outranks fetch so updates cannot starve
  always_comb begin
    w_nextState = r_state;
    query_grant = 1'b0;
    bht_we      = 1'b0;
    bht_addr    = r_lastAddr;
    bht_wdata   = 2'b01;
    case (r_state)
      INIT: begin
        bht_we   = 1'b1;
        bht_addr = r_sweepCnt;
        if (r_sweepCnt == SWEEP_LAST) w_nextState = IDLE;
      end
      IDLE: begin
        if (w_full || (!query_valid && !w_empty)) begin
          bht_addr    = w_headIdx;
          w_nextState = WB;
        end else if (query_valid) begin
          query_grant = 1'b1;
          bht_addr    = w_queryIdx;
        end
      end
      WB: begin
        bht_we      = 1'b1;
        bht_addr    = w_headIdx;
        bht_wdata   = w_satCnt;
        w_nextState = IDLE;
      end
      default: w_nextState = INIT;
    endcase
  end

  // State register and init sweep counter; reset restarts the sweep and drops any pending write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_sweepCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == INIT) r_sweepCnt <= r_sweepCnt + INDEX_LEN'(1);
    end
  end

  // Remember the last driven address so an idle port keeps it stable; flag a pending prediction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lastAddr  <= '0;
      r_predValid <= 1'b0;
    end else begin
      r_lastAddr  <= bht_addr;
      r_predValid <= query_grant;
    end
  end

  // Update queue pointers and occupancy; a push and a pop together leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage holds {hit, index}; the contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (w_push) r_fifoMem[r_wrPtr] <= {upd_hit, w_updIdx};
  end

endmodule

// File: tb/tb_bht_ctrl.sv
// Testbench for bht_ctrl. It attaches a behavioural BHT RAM and runs a
// queue-based reference model that is checked against the DUT on every
// cycle. Directed scenarios add literal expectations on the table contents.
module tb_bht_ctrl;

  localparam int IL       = 8;
  localparam int DEPTH    = 4;
  localparam int TSIZE    = 256;
  localparam int PH_INIT  = 0;
  localparam int PH_IDLE  = 1;
  localparam int PH_WB    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          upd_ena = 1'b0;
  logic          upd_hit = 1'b0;
  logic [31:0]   upd_pc = '0;
  logic          upd_full;
  logic          query_valid = 1'b0;
  logic [31:0]   query_pc = '0;
  logic          query_grant;
  logic          pred_valid;
  logic          pred_taken;
  logic          init_busy;
  logic [IL-1:0] bht_addr;
  logic          bht_we;
  logic [1:0]    bht_wdata;
  logic [1:0]    bht_rdata = 2'b00;

  logic [1:0]    tbRam [TSIZE];

  int passCount  = 0;
  int checkCount = 0;

  bht_ctrl #(.INDEX_LEN(IL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .upd_ena(upd_ena), .upd_hit(upd_hit), .upd_pc(upd_pc), .upd_full(upd_full),
    .query_valid(query_valid), .query_pc(query_pc), .query_grant(query_grant),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .init_busy(init_busy),
    .bht_addr(bht_addr), .bht_we(bht_we), .bht_wdata(bht_wdata), .bht_rdata(bht_rdata)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single-port synchronous BHT: write when enabled, otherwise register the read
  always @(posedge clk) begin
    if (bht_we) tbRam[bht_addr] <= bht_wdata;
    else        bht_rdata <= tbRam[bht_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic ena, input logic hit, input logic [31:0] upc,
                               input logic qv, input logic [31:0] qpc);
    @(posedge clk);
    #1;
    upd_ena     = ena;
    upd_hit     = hit;
    upd_pc      = upc;
    query_valid = qv;
    query_pc    = qpc;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic waitInit(input string name);
    int busyCycles;
    bit done;
    busyCycles = 0;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (init_busy) busyCycles++;
      else done = 1'b1;
    end
    checkOutput(name, busyCycles, 256);
  endtask

  task automatic queryOnce(input logic [31:0] pc, output logic taken);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, pc);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("query_pred_valid", 32'(pred_valid), 1);
    taken = pred_taken;
  endtask

  // Reference model: pending updates as a queue, the table as an int array
  typedef struct { int idx; int hit; } upd_t;
  upd_t mQ[$];
  upd_t mHead;
  int   mTable [TSIZE];
  int   mPhase = PH_INIT;
  int   mSweep = 0;
  int   mLastAddr = 0;
  int   mPrevGrant = 0;
  int   mPrevTaken = 0;
  int   eAddr, eWe, eWd, eGrant, eBusy, eFull, eTaken, cOld, cNew;

  // Compare process: mid-cycle, inputs are stable, so check then advance the model past the next edge
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_init_busy", 32'(init_busy), 1);
      checkOutput("rst_bht_we", 32'(bht_we), 1);
      checkOutput("rst_bht_addr", 32'(bht_addr), 0);
      checkOutput("rst_bht_wdata", 32'(bht_wdata), 1);
      checkOutput("rst_query_grant", 32'(query_grant), 0);
      checkOutput("rst_pred_valid", 32'(pred_valid), 0);
      checkOutput("rst_upd_full", 32'(upd_full), 0);
      mQ.delete();
      mPhase = PH_INIT;
      mSweep = 0;
      mLastAddr = 0;
      mPrevGrant = 0;
      mTable[0] = 1;
    end else begin
      eFull  = (mQ.size() == DEPTH) ? 1 : 0;
      eGrant = 0;
      eWe    = 0;
      eWd    = 0;
      eAddr  = mLastAddr;
      eTaken = 0;
      eBusy  = 0;
      checkOutput("pred_valid", 32'(pred_valid), mPrevGrant);
      if (mPrevGrant != 0) checkOutput("pred_taken", 32'(pred_taken), mPrevTaken);
      if (mPhase == PH_INIT) begin
        eBusy = 1;
        eWe   = 1;
        eWd   = 1;
        eAddr = mSweep;
        mTable[mSweep] = 1;
        mSweep++;
        if (mSweep == TSIZE) begin
          mSweep = 0;
          mPhase = PH_IDLE;
        end
      end else if (mPhase == PH_IDLE) begin
        if (mQ.size() > 0 && (eFull != 0 || !query_valid)) begin
          eAddr  = mQ[0].idx;
          mPhase = PH_WB;
        end else if (query_valid) begin
          eGrant = 1;
          eAddr  = int'(query_pc[IL+1:2]);
          eTaken = mTable[eAddr] / 2;
        end
      end else begin
        mHead = mQ.pop_front();
        cOld  = mTable[mHead.idx];
        if (mHead.hit != 0) cNew = (cOld == 3) ? 3 : cOld + 1;
        else                cNew = (cOld == 0) ? 0 : cOld - 1;
        eWe   = 1;
        eWd   = cNew;
        eAddr = mHead.idx;
        mTable[mHead.idx] = cNew;
        mPhase = PH_IDLE;
      end
      checkOutput("init_busy", 32'(init_busy), eBusy);
      checkOutput("bht_we", 32'(bht_we), eWe);
      checkOutput("bht_addr", 32'(bht_addr), eAddr);
      checkOutput("query_grant", 32'(query_grant), eGrant);
      checkOutput("upd_full", 32'(upd_full), eFull);
      if (eWe != 0) checkOutput("bht_wdata", 32'(bht_wdata), eWd);
      if (upd_ena && eFull == 0) mQ.push_back('{idx: int'(upd_pc[IL+1:2]), hit: int'(upd_hit)});
      mPrevGrant = eGrant;
      mPrevTaken = eTaken;
      mLastAddr  = eAddr;
    end
  end

  // Watchdog so a stuck design still ends the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int   exp037 [3] = '{2, 3, 3};
  logic taken;

  // Directed scenarios
  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    waitInit("init_busy_cycles");

    // Not-taken update drives the counter to 00, then two taken updates reach 10
    applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 32'h0);
    idleCycles(5);
    checkOutput("ram_10_after_nt", 32'(tbRam[8'h10]), 0);
    queryOnce(32'h40, taken);
    checkOutput("pred_after_nt", 32'(taken), 0);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    idleCycles(6);
    checkOutput("ram_10_after_two_t", 32'(tbRam[8'h10]), 2);
    queryOnce(32'h40, taken);
    checkOutput("pred_after_two_t", 32'(taken), 1);

    // Reset in the write-back cycle: the pending write must never land
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abandoned_wb_ram_20", 32'(tbRam[8'h20]), 1);
    checkOutput("reset_addr_zero", 32'(bht_addr), 0);
    checkOutput("reset_fifo_not_full", 32'(upd_full), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    waitInit("reinit_busy_cycles");
    idleCycles(4);
    checkOutput("no_stale_update_ram_20", 32'(tbRam[8'h20]), 1);
    checkOutput("reinit_ram_10", 32'(tbRam[8'h10]), 1);

    // Three taken updates saturate at 11
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
      idleCycles(4);
      checkOutput("saturate_ram_10", 32'(tbRam[8'h10]), exp037[k]);
    end

    // A held query starves a single pending update until fetch goes quiet
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 32'h40);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    @(negedge clk);
    checkOutput("held_query_granted", 32'(query_grant), 1);
    checkOutput("held_query_ram_80", 32'(tbRam[8'h80]), 1);
    idleCycles(4);
    checkOutput("released_update_ram_80", 32'(tbRam[8'h80]), 2);

    // Five back-to-back updates under query pressure: the fifth is dropped
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, 32'h100 + 32'(4 * k), 1'b1, 32'h40);
    @(negedge clk);
    checkOutput("fifth_update_full", 32'(upd_full), 1);
    checkOutput("full_beats_query", 32'(query_grant), 0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    idleCycles(10);
    for (int k = 0; k < 4; k++) checkOutput("burst_written", 32'(tbRam[8'h40 + 8'(k)]), 2);
    checkOutput("burst_dropped_ram_44", 32'(tbRam[8'h44]), 1);

    idleCycles(2);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bht_ctrl.md
BHT_CTRL -- requirements
Module: bht_ctrl

Interface
REQ-001 Parameter: INDEX_LEN, default 8, BHT index width; table depth is 2^INDEX_LEN.
REQ-002 Parameter: FIFO_DEPTH, default 4, number of update-queue entries; must be a power of two.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 upd_ena  in  1  ROB commit of a resolved branch; one update per cycle.
REQ-006 upd_hit  in  1  1 = branch was taken, 0 = not taken.
REQ-007 upd_pc  in  32  PC of the committed branch; index = upd_pc[INDEX_LEN+1:2].
REQ-008 upd_full  out  1  update FIFO full; an upd_ena in this cycle is dropped.
REQ-009 query_valid  in  1  fetch requests a prediction read.
REQ-010 query_pc  in  32  fetch PC; index = query_pc[INDEX_LEN+1:2].
REQ-011 query_grant  out  1  combinational; the query owns the BHT port this cycle.
REQ-012 pred_valid  out  1  registered; pred_taken is valid this cycle.
REQ-013 pred_taken  out  1  bht_rdata[1] of the granted query.
REQ-014 init_busy  out  1  table initialisation sweep is in progress.
REQ-015 bht_addr  out  INDEX_LEN  single-port BHT address.
REQ-016 bht_we  out  1  BHT write enable.
REQ-017 bht_wdata  out  2  BHT write data.
REQ-018 bht_rdata  in  2  BHT read data; valid one cycle after a read address is presented with bht_we=0.

Function
REQ-019 The block shall own the sole BHT port and run an FSM with states INIT, IDLE and WB.
REQ-020 INIT: write 2'b01 (weakly not taken) to address sweep_cnt every cycle, with sweep_cnt running 0 to 2^INDEX_LEN-1, then enter IDLE; init_busy=1 throughout INIT.
REQ-021 INIT shall grant no queries; updates arriving during INIT are enqueued (subject to full) and held until INIT completes.
REQ-022 IDLE port priority: (a) if the FIFO is full, issue a read of the head entry; (b) else if query_valid, grant the query; (c) else if the FIFO is non-empty, issue a read of the head entry; (d) else drive no access.
REQ-023 A head-entry read shall move the FSM to WB; every other IDLE outcome shall remain in IDLE.
REQ-024 WB: counter c = bht_rdata; write back sat(c+1) if the head entry's hit=1, else sat(c-1); saturate at 2'b11 and 2'b00.
REQ-025 WB: write to the head entry's index, pop the FIFO, return to IDLE, and grant no query.
REQ-026 Exactly one read-modify-write shall be in flight at a time, so no intra-block RAW hazard exists.
REQ-027 Query: when query_grant=1, drive bht_addr=query index and bht_we=0; on the next cycle pred_valid=1 and pred_taken=bht_rdata[1]; otherwise pred_valid=0.
REQ-028 FIFO entry = {hit, index}; push on upd_ena when not full; full is registered state, so a push is dropped when the FIFO is full even if a pop occurs the same cycle.
REQ-029 The FIFO pointers shall be log2(FIFO_DEPTH) bits wide with wrap-around, plus a count register of log2(FIFO_DEPTH)+1 bits.
REQ-030 A simultaneous push and pop on a non-full FIFO shall leave the count unchanged.
REQ-031 When no access is driven, bht_we=0 and bht_addr holds its last value.

Reset
REQ-032 Asserting rst shall immediately force state=INIT, sweep_cnt=0, FIFO empty, pred_valid=0 and upd_full=0.
REQ-033 While rst is high, outputs shall be init_busy=1, bht_we=1, bht_addr=0, bht_wdata=2'b01 and query_grant=0.
REQ-034 Reset during WB shall abandon the pending write; the restarted INIT sweep rewrites the whole table.
REQ-035 After rst falls, the first IDLE cycle shall be exactly 2^INDEX_LEN cycles later.

Verification
REQ-036 Reset release -> 256 consecutive writes of 01 to addresses 0..255, then init_busy=0.
REQ-037 After init, three upd_ena with hit=1 and pc=0x40 -> index 0x10 holds 10, then 11, then stays 11 (saturates).
REQ-038 query_valid held high with one pending update -> queries granted every IDLE cycle; the update starts only in a cycle with query_valid=0.
REQ-039 Five updates in back-to-back cycles with query_valid=1 -> fifth dropped (upd_full=1), updates win the port while full, four writes complete.
REQ-040 Update pc=0x40 hit=0, then query pc=0x40 -> pred_taken=0 (counter 00); after two hit=1 updates, query -> pred_taken=1.
REQ-041 rst pulsed during WB -> no write lands at the head index, FIFO empty, sweep restarts at address 0.
